mmu_utlb: RTL
=============

MMU_UTLB -- requirements
Module: mmu_utlb

Interface
REQ-001 Param N_INST_CHANNEL, default 2: instruction channels sharing one fetch page; one lookup per cycle.
REQ-002 Param N_ISSUE, default 2: data ports.
REQ-003 Param N_ITLB / N_DTLB, default 4 / 8: micro-TLB entries, fully associative; power of 2, at least 2.
REQ-004 clk  in  1: sole clock, rising edge.
REQ-005 rst  in  1: reset, asynchronous, active-low.
REQ-006 asid in 8; kseg0_uncached in 1; is_user_mode in 1: CP0 state.
REQ-007 flush  in  1: pulse on TLBWI/TLBWR or ASID write.
REQ-008 inst_req in 1; inst_vaddr in [N_INST_CHANNEL] virt_t: fetch request and addresses.
REQ-009 inst_resp_valid out 1; inst_resp out [N_INST_CHANNEL] mmu_resp_t.
REQ-010 data_req in [N_ISSUE]; data_vaddr in [N_ISSUE] virt_t.
REQ-011 data_resp_valid out [N_ISSUE]; data_resp out [N_ISSUE] mmu_resp_t.
REQ-012 lookup_req out 1; lookup_vaddr out 32: main-TLB request, held until ack.
REQ-013 lookup_ack in 1; lookup_resp in tlb_resp_t: main-TLB result, valid with ack.

Function
REQ-014 Unmapped or illegal (is_user_mode and vaddr[31]) requests SHALL respond combinationally in the same cycle, with no lookup; paddr = {3'b0, vaddr[28:0]}; illegal flag set.
REQ-015 Entry: vpn[31:12], asid, global, pfn[31:12], dirty, cache_flag[2:0], valid. Hit = valid and vpn match and (global or asid match).
REQ-016 Mapped hit SHALL set resp_valid in the same cycle: paddr = {pfn, vaddr[11:0]}; uncached when cache_flag == 2; dirty from entry.
REQ-017 All inst channels SHALL use inst_vaddr[0]'s page; inst_resp_valid is common to all channels.
REQ-018 FSM states: IDLE, LOOKUP, FILL, FAULT.
REQ-019 IDLE, any mapped miss: latch requester and vaddr, go to LOOKUP. Priority: lowest-index data port, then inst.
REQ-020 LOOKUP: lookup_req = 1. On ack with hit and valid, go to FILL. On ack with miss or not valid, go to FAULT.
REQ-021 FILL writes the owning micro-TLB at its FIFO pointer, then increments the pointer modulo depth (wraps N-1 to 0), then goes to IDLE; the requester hits the following cycle.
REQ-022 FAULT lasts one cycle: the owning port gets resp_valid = 1 with miss or inv set, only if it still requests the latched vaddr[31:12]. FAULT then goes to IDLE. Nothing is cached.
REQ-023 Minimum miss latency: miss at cycle t, lookup_req at t+1, ack at t+1, FILL at t+2, hit at t+3.
REQ-024 Flush SHALL clear all valid bits on that edge and leave pointers unchanged.
REQ-025 Flush in LOOKUP SHALL set a discard flag; the ack then returns to IDLE with no fill or fault. Flush in FILL or FAULT SHALL suppress the write or response.
REQ-026 Flush during FILL takes priority: the entry is not written.
REQ-027 Other ports missing while the FSM is busy SHALL keep resp_valid = 0 and are served in later IDLE cycles.
REQ-028 Two data ports missing on the same page SHALL be refilled once; the second port hits after FILL.
REQ-029 resp vaddr SHALL always echo the input; resp_valid SHALL be 0 when the corresponding req = 0.

Reset
REQ-030 Reset SHALL clear all valid bits, set pointers to 0, state to IDLE, and discard to 0. lookup_req = 0 and all resp_valid = 0 during reset.
REQ-031 Reset during LOOKUP SHALL abandon the request; a later ack with state IDLE SHALL be ignored.

Structure
REQ-032 utlb_entry_t, utlb_state_t and the depth constants SHALL live in the shared MMU package, beside mmu_resp_t and tlb_resp_t.
REQ-033 Sub-module utlb_array (entries, hit/match logic, FIFO pointer) SHALL be instantiated twice: ITLB and DTLB.

Verification
REQ-034 Reset, then data_vaddr 0x8000_1234 -> same-cycle resp_valid = 1, paddr 0x0000_1234, no lookup_req.
REQ-035 Data mapped miss at 0x0040_0010, ack at the next cycle with pfn 0x12345, valid, dirty -> hit 2 cycles after ack with paddr 0x1234_5010 and dirty = 1.
REQ-036 Fill DTLB 9 distinct pages (N_DTLB = 8) -> the 1st page misses again and the 9th hits (pointer wrap).
REQ-037 Flush asserted while in LOOKUP, then ack -> no fill, FSM returns to IDLE, the same vaddr issues a new lookup_req.
REQ-038 inst and data_req[1] miss in the same cycle -> data is served first, inst lookup follows, both eventually hit.
REQ-039 Ack returns miss for 0x0000_2000 -> one-cycle resp_valid with miss = 1, then no micro-TLB entry for that page.

Source files
------------

// File: rtl/mmu_utlb_pkg.sv
// Shared MMU types: micro-TLB entries, main-TLB result, translation response and helpers.
package mmu_utlb_pkg;

  localparam int unsigned VPN_W      = 20;
  localparam int unsigned ASID_W     = 8;
  localparam int unsigned N_ITLB_DEF = 4;
  localparam int unsigned N_DTLB_DEF = 8;

  typedef logic [31:0] virt_t;

  typedef struct packed {
    virt_t       vaddr;
    logic [31:0] paddr;
    logic        miss;
    logic        invalid;
    logic        illegal;
    logic        uncached;
    logic        dirty;
  } mmu_resp_t;

  typedef struct packed {
    logic             miss;
    logic             valid;
    logic             dirty;
    logic             glb;
    logic [2:0]       cache_flag;
    logic [VPN_W-1:0] pfn;
  } tlb_resp_t;

  typedef struct packed {
    logic              valid;
    logic [VPN_W-1:0]  vpn;
    logic [ASID_W-1:0] asid;
    logic              glb;
    logic [VPN_W-1:0]  pfn;
    logic              dirty;
    logic [2:0]        cache_flag;
  } utlb_entry_t;

  typedef struct packed {
    logic [VPN_W-1:0] pfn;
    logic             dirty;
    logic [2:0]       cache_flag;
  } utlb_hit_t;

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_FILL, ST_FAULT} utlb_state_t;

  // kseg0/kseg1 are unmapped; any kernel segment from user mode is illegal
  function automatic logic is_direct(input logic [1:0] top2, input logic user);
    return (top2 == 2'b10) || (user && top2[1]);
  endfunction

  function automatic mmu_resp_t build_resp(input virt_t va, input logic [VPN_W-1:0] page_vpn,
                                           input logic user, input logic k0_unc,
                                           input logic hit, input utlb_hit_t ent,
                                           input logic fault, input logic f_miss,
                                           input logic f_inv);
    mmu_resp_t r;
    r       = '0;
    r.vaddr = va;
    if (is_direct(page_vpn[19:18], user)) begin
      r.paddr    = {3'b000, page_vpn[16:0], va[11:0]};
      r.illegal  = user && page_vpn[19];
      r.uncached = (page_vpn[19:17] == 3'b101) || ((page_vpn[19:17] == 3'b100) && k0_unc);
    end else if (hit) begin
      r.paddr    = {ent.pfn, va[11:0]};
      r.uncached = (ent.cache_flag == 3'd2);
      r.dirty    = ent.dirty;
    end else if (fault) begin
      r.miss    = f_miss;
      r.invalid = f_inv;
    end
    return r;
  endfunction

endpackage

// File: rtl/mmu_utlb_array.sv
// Fully associative micro-TLB with FIFO replacement and N_PORT parallel lookups.
module mmu_utlb_array
  import mmu_utlb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned N_PORT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              we_i,
  input  utlb_entry_t       wdata_i,
  input  logic [ASID_W-1:0] asid_i,
  input  logic [VPN_W-1:0]  vpn_i   [N_PORT],
  output logic              hit_o   [N_PORT],
  output utlb_hit_t         entry_o [N_PORT]
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  utlb_entry_t      ent_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;

  // Flush clears valid bits only; the replacement pointer keeps its position
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
      ptr_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i].valid <= 1'b0;
    end else if (we_i) begin
      ent_q[ptr_q] <= wdata_i;
      ptr_q        <= ptr_q + PTR_W'(1);
    end
  end

  always_comb begin
    for (int p = 0; p < int'(N_PORT); p++) begin
      hit_o[p]   = 1'b0;
      entry_o[p] = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (ent_q[i].valid && (ent_q[i].vpn == vpn_i[p]) &&
            (ent_q[i].glb || (ent_q[i].asid == asid_i))) begin
          hit_o[p]   = 1'b1;
          entry_o[p] = '{pfn: ent_q[i].pfn, dirty: ent_q[i].dirty,
                         cache_flag: ent_q[i].cache_flag};
        end
      end
    end
  end

endmodule

// File: rtl/mmu_utlb.sv
// Instruction/data micro-TLBs with a shared refill FSM in front of the main TLB.
module mmu_utlb
  import mmu_utlb_pkg::*;
#(
  parameter int unsigned N_INST_CHANNEL = 2,
  parameter int unsigned N_ISSUE        = 2,
  parameter int unsigned N_ITLB         = N_ITLB_DEF,
  parameter int unsigned N_DTLB         = N_DTLB_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [ASID_W-1:0]  asid_i,
  input  logic               kseg0_uncached_i,
  input  logic               is_user_mode_i,
  input  logic               flush_i,
  input  logic               inst_req_i,
  input  virt_t              inst_vaddr_i      [N_INST_CHANNEL],
  output logic               inst_resp_valid_o,
  output mmu_resp_t          inst_resp_o       [N_INST_CHANNEL],
  input  logic [N_ISSUE-1:0] data_req_i,
  input  virt_t              data_vaddr_i      [N_ISSUE],
  output logic [N_ISSUE-1:0] data_resp_valid_o,
  output mmu_resp_t          data_resp_o       [N_ISSUE],
  output logic               lookup_req_o,
  output logic [31:0]        lookup_vaddr_o,
  input  logic               lookup_ack_i,
  input  tlb_resp_t          lookup_resp_i
);

  localparam int unsigned OWN_W = $clog2(N_ISSUE + 1);
  localparam logic [OWN_W-1:0] OWN_INST = OWN_W'(N_ISSUE);

  utlb_state_t      state_q;
  logic [OWN_W-1:0] owner_q;
  virt_t            vaddr_q;
  logic             discard_q;
  logic             fmiss_q;
  logic             finv_q;
  logic             lookup_req_q;
  utlb_entry_t      fill_q;

  logic             d_hit    [N_ISSUE];
  utlb_hit_t        d_ent    [N_ISSUE];
  logic [VPN_W-1:0] d_vpn    [N_ISSUE];
  logic             d_direct [N_ISSUE];
  logic             d_fault  [N_ISSUE];
  logic             i_hit    [1];
  utlb_hit_t        i_ent    [1];
  logic [VPN_W-1:0] i_vpn    [1];
  logic             i_direct;
  logic             i_fault;
  logic             d_we;
  logic             i_we;
  logic             any_miss;
  logic [OWN_W-1:0] sel_owner;
  virt_t            sel_vaddr;

  assign d_we = (state_q == ST_FILL) && !flush_i && (owner_q != OWN_INST);
  assign i_we = (state_q == ST_FILL) && !flush_i && (owner_q == OWN_INST);

  mmu_utlb_array #(.DEPTH(N_DTLB), .N_PORT(N_ISSUE)) u_dtlb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .we_i    (d_we),
    .wdata_i (fill_q),
    .asid_i  (asid_i),
    .vpn_i   (d_vpn),
    .hit_o   (d_hit),
    .entry_o (d_ent)
  );

  mmu_utlb_array #(.DEPTH(N_ITLB), .N_PORT(1)) u_itlb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .we_i    (i_we),
    .wdata_i (fill_q),
    .asid_i  (asid_i),
    .vpn_i   (i_vpn),
    .hit_o   (i_hit),
    .entry_o (i_ent)
  );

  // Combinational responses and miss arbitration (lowest data port first, then inst)
  always_comb begin
    any_miss  = 1'b0;
    sel_owner = '0;
    sel_vaddr = '0;
    i_vpn[0]  = inst_vaddr_i[0][31:12];
    i_direct  = is_direct(inst_vaddr_i[0][31:30], is_user_mode_i);
    i_fault   = (state_q == ST_FAULT) && !flush_i && (owner_q == OWN_INST) &&
                (inst_vaddr_i[0][31:12] == vaddr_q[31:12]);
    inst_resp_valid_o = rst_ni && inst_req_i && (i_direct || i_hit[0] || i_fault);
    for (int c = 0; c < int'(N_INST_CHANNEL); c++) begin
      inst_resp_o[c] = build_resp(inst_vaddr_i[c], inst_vaddr_i[0][31:12], is_user_mode_i,
                                  kseg0_uncached_i, i_hit[0], i_ent[0], i_fault,
                                  fmiss_q, finv_q);
    end
    if (inst_req_i && !i_direct && !i_hit[0]) begin
      any_miss  = 1'b1;
      sel_owner = OWN_INST;
      sel_vaddr = inst_vaddr_i[0];
    end
    for (int p = int'(N_ISSUE) - 1; p >= 0; p--) begin
      d_vpn[p]    = data_vaddr_i[p][31:12];
      d_direct[p] = is_direct(data_vaddr_i[p][31:30], is_user_mode_i);
      d_fault[p]  = (state_q == ST_FAULT) && !flush_i && (owner_q == OWN_W'(p)) &&
                    (data_vaddr_i[p][31:12] == vaddr_q[31:12]);
      data_resp_valid_o[p] = rst_ni && data_req_i[p] && (d_direct[p] || d_hit[p] || d_fault[p]);
      data_resp_o[p] = build_resp(data_vaddr_i[p], data_vaddr_i[p][31:12], is_user_mode_i,
                                  kseg0_uncached_i, d_hit[p], d_ent[p], d_fault[p],
                                  fmiss_q, finv_q);
      if (data_req_i[p] && !d_direct[p] && !d_hit[p]) begin
        any_miss  = 1'b1;
        sel_owner = OWN_W'(p);
        sel_vaddr = data_vaddr_i[p];
      end
    end
  end

  // Refill FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      vaddr_q      <= '0;
      discard_q    <= 1'b0;
      fmiss_q      <= 1'b0;
      finv_q       <= 1'b0;
      lookup_req_q <= 1'b0;
      fill_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_miss) begin
            state_q      <= ST_LOOKUP;
            owner_q      <= sel_owner;
            vaddr_q      <= sel_vaddr;
            lookup_req_q <= 1'b1;
            discard_q    <= 1'b0;
          end
        end
        ST_LOOKUP: begin
          if (lookup_ack_i) begin
            lookup_req_q <= 1'b0;
            discard_q    <= 1'b0;
            if (discard_q || flush_i) begin
              state_q <= ST_IDLE;
            end else if (!lookup_resp_i.miss && lookup_resp_i.valid) begin
              state_q <= ST_FILL;
              fill_q  <= '{valid: 1'b1, vpn: vaddr_q[31:12], asid: asid_i,
                           glb: lookup_resp_i.glb, pfn: lookup_resp_i.pfn,
                           dirty: lookup_resp_i.dirty,
                           cache_flag: lookup_resp_i.cache_flag};
            end else begin
              state_q <= ST_FAULT;
              fmiss_q <= lookup_resp_i.miss;
              finv_q  <= !lookup_resp_i.miss;
            end
          end else if (flush_i) begin
            discard_q <= 1'b1;
          end
        end
        ST_FILL:  state_q <= ST_IDLE;
        ST_FAULT: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign lookup_req_o   = lookup_req_q;
  assign lookup_vaddr_o = vaddr_q;

endmodule
